// File: rtl/paula_audio_mix_pkg.sv
// paula_audio_mix_pkg: FSM encoding, widths, saturation limits and helpers for the Paula mixer
package paula_audio_mix_pkg;
  localparam int SMP_W   = 8;
  localparam int VOL_W   = 7;
  localparam int PROD_W  = 15;
  localparam int SUM_W   = 16;
  localparam int OUT_W   = 9;
  localparam int OUT_MAX = 255;
  localparam int OUT_MIN = -256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAP,
    ST_MUL0,
    ST_MUL1,
    ST_MUL2,
    ST_MUL3,
    ST_SUM,
    ST_OUT
  } state_t;

  function automatic logic [VOL_W-1:0] clamp_vol(input logic [VOL_W-1:0] v);
    return v[6] ? 7'd64 : {1'b0, v[5:0]};
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] s);
    return (s > SUM_W'(OUT_MAX)) ? OUT_W'(OUT_MAX) :
           (s < SUM_W'(OUT_MIN)) ? OUT_W'(OUT_MIN) : s[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/paula_audio_mix_lpf.sv
// paula_audio_mix_lpf: one-pole LED low-pass, y += (x - y) >>> FILT_SHIFT, or pass-through when filt is low
module paula_audio_mix_lpf
  import paula_audio_mix_pkg::*;
#(
  parameter int FILT_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    upd,
  input  logic                    filt,
  input  logic signed [OUT_W-1:0] x,
  output logic signed [OUT_W-1:0] y
);
  localparam int YW = OUT_W + FILT_SHIFT;

  logic signed [YW-1:0] y_q, y_d;
  logic signed [YW:0]   xs, diff;

  // fixed-point filter step on each new mix
  always_comb begin
    xs   = (YW+1)'(x) <<< FILT_SHIFT;
    diff = xs - (YW+1)'(y_q);
    y_d  = !upd ? y_q : filt ? YW'((YW+1)'(y_q) + (diff >>> FILT_SHIFT)) : YW'(xs);
  end

  // filter state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) y_q <= '0;
    else          y_q <= y_d;
  end

  assign y = y_q[YW-1:FILT_SHIFT];
endmodule

// File: rtl/paula_audio_mixer.sv
// paula_audio_mixer: Paula 4-channel stereo mixer on one shared multiplier; LED filter under PAULA_MIXER_LPF_EN
module paula_audio_mixer
  import paula_audio_mix_pkg::*;
#(
  parameter int GAIN_SHIFT = 6,
  parameter int FILT_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mix_start,
  input  logic [SMP_W-1:0]        aud0,
  input  logic [SMP_W-1:0]        aud1,
  input  logic [SMP_W-1:0]        aud2,
  input  logic [SMP_W-1:0]        aud3,
  input  logic [VOL_W-1:0]        vol0,
  input  logic [VOL_W-1:0]        vol1,
  input  logic [VOL_W-1:0]        vol2,
  input  logic [VOL_W-1:0]        vol3,
  input  logic                    led_filt,
  output logic signed [OUT_W-1:0] ldatasum,
  output logic signed [OUT_W-1:0] rdatasum,
  output logic                    mix_valid,
  output logic                    busy,
  output logic                    overrun
);
  state_t                   state_q, state_d;
  logic [SMP_W-1:0]         aud_q [4];
  logic [SMP_W-1:0]         aud_d [4];
  logic [VOL_W-1:0]         vol_q [4];
  logic [VOL_W-1:0]         vol_d [4];
  logic signed [PROD_W-1:0] prod_q [4];
  logic signed [PROD_W-1:0] prod_d [4];
  logic                     mix_valid_q, mix_valid_d;
  logic                     overrun_q, overrun_d;
  logic [1:0]               mul_idx;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  suml, sumr;
  logic signed [OUT_W-1:0]  xl, xr;
  logic                     upd;

  // sequencing, capture, shared multiply and scaled channel-pair sums
  always_comb begin
    state_d     = state_q;
    aud_d       = aud_q;
    vol_d       = vol_q;
    prod_d      = prod_q;
    mul_idx     = 2'(state_q - ST_MUL0);
    prod        = PROD_W'($signed(aud_q[mul_idx])) * PROD_W'($signed({1'b0, vol_q[mul_idx]}));
    suml        = SUM_W'(prod_q[0]) + SUM_W'(prod_q[3]);
    sumr        = SUM_W'(prod_q[1]) + SUM_W'(prod_q[2]);
    xl          = sat_out(suml >>> GAIN_SHIFT);
    xr          = sat_out(sumr >>> GAIN_SHIFT);
    upd         = state_q == ST_SUM;
    mix_valid_d = upd;
    overrun_d   = overrun_q | (mix_start & (state_q != ST_IDLE));
    if (state_q == ST_IDLE) state_d = mix_start ? ST_CAP : ST_IDLE;
    else                    state_d = (state_q == ST_OUT) ? ST_IDLE : state_t'(state_q + 3'd1);
    if (state_q == ST_CAP) begin
      aud_d = '{aud0, aud1, aud2, aud3};
      vol_d = '{clamp_vol(vol0), clamp_vol(vol1), clamp_vol(vol2), clamp_vol(vol3)};
    end
    if (state_q inside {ST_MUL0, ST_MUL1, ST_MUL2, ST_MUL3}) prod_d[mul_idx] = prod;
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      aud_q       <= '{default: '0};
      vol_q       <= '{default: '0};
      prod_q      <= '{default: '0};
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      aud_q       <= aud_d;
      vol_q       <= vol_d;
      prod_q      <= prod_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mix_valid = mix_valid_q;
  assign overrun   = overrun_q;
  assign busy      = state_q != ST_IDLE;

`ifdef PAULA_MIXER_LPF_EN
  paula_audio_mix_lpf #(.FILT_SHIFT(FILT_SHIFT)) u_lpf_l (
    .clk(clk), .reset_n(reset_n), .upd(upd), .filt(led_filt), .x(xl), .y(ldatasum)
  );
  paula_audio_mix_lpf #(.FILT_SHIFT(FILT_SHIFT)) u_lpf_r (
    .clk(clk), .reset_n(reset_n), .upd(upd), .filt(led_filt), .x(xr), .y(rdatasum)
  );
`else
  localparam int unused_filt_shift = FILT_SHIFT;
  logic unused_led_filt;
  logic signed [OUT_W-1:0] ldatasum_q, ldatasum_d, rdatasum_q, rdatasum_d;
  assign unused_led_filt = led_filt;

  // load the new mix, hold it otherwise
  always_comb begin
    ldatasum_d = upd ? xl : ldatasum_q;
    rdatasum_d = upd ? xr : rdatasum_q;
  end

  // output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ldatasum_q <= '0;
      rdatasum_q <= '0;
    end else begin
      ldatasum_q <= ldatasum_d;
      rdatasum_q <= rdatasum_d;
    end
  end

  assign ldatasum = ldatasum_q;
  assign rdatasum = rdatasum_q;
`endif
endmodule
